// File: rtl/mac_tx_streamer_pkg.sv
// rtl/mac_tx_streamer_pkg.sv - shared constants and types for the MAC TX streamer
package mac_tx_streamer_pkg;

    localparam int DATAWIDTH = 32;
    localparam int MAX_BYTES_DEFAULT = 1518;

    localparam logic [DATAWIDTH-1:0] START_WORD = 32'hF00BF00B;
    localparam logic [DATAWIDTH-1:0] STOP_WORD  = 32'hDEADF00B;

    typedef enum logic [2:0] {
        HUNT,
        LEN,
        PAYLOAD,
        TRAILER,
        DISCARD
    } tx_state_t;

    // Unused byte lanes in the final beat: (4 - byte_cnt[1:0]) mod 4.
    function automatic logic [1:0] eop_empty(input logic [1:0] byte_lo);
        logic [2:0] diff;
        diff = 3'd4 - {1'b0, byte_lo};
        return diff[1:0];
    endfunction

endpackage

// File: rtl/mac_tx_streamer_if.sv
// rtl/mac_tx_streamer_if.sv - FIFO read side and Avalon-ST source bundle
interface mac_tx_streamer_if;
    import mac_tx_streamer_pkg::*;

    logic [DATAWIDTH-1:0] fifo_rddata;
    logic                 fifo_rdempty;
    logic                 fifo_rdreq;

    logic [DATAWIDTH-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic                 tx_sop;
    logic                 tx_eop;
    logic [1:0]           tx_empty;

    // Streamer view: consumes the FIFO, drives the stream.
    modport master (
        input  fifo_rddata, fifo_rdempty, tx_ready,
        output fifo_rdreq, tx_data, tx_valid, tx_sop, tx_eop, tx_empty
    );

    // Environment view: provides the FIFO, sinks the stream.
    modport slave (
        output fifo_rddata, fifo_rdempty, tx_ready,
        input  fifo_rdreq, tx_data, tx_valid, tx_sop, tx_eop, tx_empty
    );

endinterface

// File: rtl/mac_tx_streamer_st_out_reg.sv
// rtl/mac_tx_streamer_st_out_reg.sv - one-entry Avalon-ST output register
module mac_tx_streamer_st_out_reg
    import mac_tx_streamer_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load_i,
    input  logic                 accept_i,
    input  logic [DATAWIDTH-1:0] data_i,
    input  logic                 sop_i,
    input  logic                 eop_i,
    input  logic [1:0]           empty_i,
    output logic                 valid_o,
    output logic [DATAWIDTH-1:0] data_o,
    output logic                 sop_o,
    output logic                 eop_o,
    output logic [1:0]           empty_o
);

    logic                 valid_q;
    logic [DATAWIDTH-1:0] data_q;
    logic                 sop_q;
    logic                 eop_q;
    logic [1:0]           empty_q;

    // Load replaces the held beat (caller only loads when empty or accepted);
    // an accept without a load empties the slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            empty_q <= 2'b00;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
            sop_q   <= sop_i;
            eop_q   <= eop_i;
            empty_q <= empty_i;
        end else if (accept_i) begin
            valid_q <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            empty_q <= 2'b00;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign sop_o   = sop_q;
    assign eop_o   = eop_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/mac_tx_streamer.sv
// rtl/mac_tx_streamer.sv - unframes FIFO records into an Avalon-ST packet source
module mac_tx_streamer
    import mac_tx_streamer_pkg::*;
#(
    parameter int MAX_BYTES = MAX_BYTES_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tx_enable,
    mac_tx_streamer_if.master     st,
    output logic                  busy,
    output logic [15:0]           pkt_count,
    output logic [15:0]           err_count,
    output logic                  frame_err
);

    localparam logic [15:0] MAX_LEN = 16'(MAX_BYTES);

    tx_state_t   state_q;
    logic [10:0] words_left_q;
    logic [1:0]  byte_lo_q;
    logic        first_q;
    logic [15:0] pkt_q;
    logic [15:0] err_q;
    logic        frame_err_q;

    logic                 tx_valid_w;
    logic [DATAWIDTH-1:0] tx_data_w;
    logic                 tx_sop_w;
    logic                 tx_eop_w;
    logic [1:0]           tx_empty_w;

    logic        accept;
    logic        slot_free;
    logic        want_pop;
    logic        pop;
    logic        load;
    logic        err_evt;
    logic        last_word;
    logic [15:0] len;
    logic [10:0] len_words;

    assign accept    = tx_valid_w && st.tx_ready;
    assign slot_free = !tx_valid_w || accept;
    assign len       = st.fifo_rddata[15:0];
    assign len_words = 11'((len + 16'd3) >> 2);
    assign last_word = (words_left_q == 11'd1);

    // Only payload words wait for room in the output slot; framing words are
    // popped freely, and HUNT holds off while transmission is disabled.
    always_comb begin
        want_pop = 1'b1;
        case (state_q)
            HUNT:    want_pop = tx_enable;
            PAYLOAD: want_pop = slot_free;
            default: want_pop = 1'b1;
        endcase
    end

    assign pop  = !st.fifo_rdempty && want_pop;
    assign load = pop && (state_q == PAYLOAD);

    // An error is an oversize length or a trailer that is not STOP.
    always_comb begin
        err_evt = 1'b0;
        if (pop) begin
            if (state_q == LEN && len > MAX_LEN) begin
                err_evt = 1'b1;
            end else if (state_q == TRAILER && st.fifo_rddata != STOP_WORD) begin
                err_evt = 1'b1;
            end
        end
    end

    // Record parser: advances one FIFO word per pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= HUNT;
            words_left_q <= '0;
            byte_lo_q    <= 2'b00;
            first_q      <= 1'b0;
        end else if (pop) begin
            case (state_q)
                HUNT: begin
                    if (st.fifo_rddata == START_WORD) begin
                        state_q <= LEN;
                    end
                end
                LEN: begin
                    if (len == 16'd0) begin
                        state_q <= TRAILER;
                    end else if (len > MAX_LEN) begin
                        state_q <= DISCARD;
                    end else begin
                        words_left_q <= len_words;
                        byte_lo_q    <= len[1:0];
                        first_q      <= 1'b1;
                        state_q      <= PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    first_q      <= 1'b0;
                    words_left_q <= words_left_q - 11'd1;
                    if (last_word) begin
                        state_q <= TRAILER;
                    end
                end
                TRAILER: begin
                    state_q <= HUNT;
                end
                DISCARD: begin
                    if (st.fifo_rddata == STOP_WORD) begin
                        state_q <= HUNT;
                    end
                end
                default: begin
                    state_q <= HUNT;
                end
            endcase
        end
    end

    // Status counters: packets count on eop acceptance, errors saturate.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pkt_q       <= '0;
            err_q       <= '0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= err_evt;
            if (accept && tx_eop_w) begin
                pkt_q <= pkt_q + 16'd1;
            end
            if (err_evt && err_q != 16'hFFFF) begin
                err_q <= err_q + 16'd1;
            end
        end
    end

    mac_tx_streamer_st_out_reg u_out (
        .clk      (clk),
        .reset    (reset),
        .load_i   (load),
        .accept_i (accept),
        .data_i   (st.fifo_rddata),
        .sop_i    (first_q),
        .eop_i    (last_word),
        .empty_i  (last_word ? eop_empty(byte_lo_q) : 2'b00),
        .valid_o  (tx_valid_w),
        .data_o   (tx_data_w),
        .sop_o    (tx_sop_w),
        .eop_o    (tx_eop_w),
        .empty_o  (tx_empty_w)
    );

    assign st.fifo_rdreq = pop;
    assign st.tx_valid   = tx_valid_w;
    assign st.tx_data    = tx_data_w;
    assign st.tx_sop     = tx_sop_w;
    assign st.tx_eop     = tx_eop_w;
    assign st.tx_empty   = tx_empty_w;

    assign busy      = (state_q != HUNT) || tx_valid_w;
    assign pkt_count = pkt_q;
    assign err_count = err_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_mac_tx_streamer.sv
// tb/tb_mac_tx_streamer.sv - self-checking bench for mac_tx_streamer
module tb_mac_tx_streamer;
    import mac_tx_streamer_pkg::*;

    typedef struct packed {
        logic [31:0] data;
        logic        sop;
        logic        eop;
        logic [1:0]  empty;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        tx_enable;
    logic        busy;
    logic        frame_err;
    logic [15:0] pkt_count;
    logic [15:0] err_count;

    mac_tx_streamer_if bus ();

    mac_tx_streamer dut (
        .clk       (clk),
        .reset     (reset),
        .tx_enable (tx_enable),
        .st        (bus),
        .busy      (busy),
        .pkt_count (pkt_count),
        .err_count (err_count),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] fifo_q[$];
    beat_t       got_q[$];
    beat_t       exp_q[$];
    int          exp_pkt   = 0;
    int          exp_err   = 0;
    int          exp_fe    = 0;
    int          fe_pulses = 0;
    int          hold_viol = 0;
    int          ready_mode = 0;

    // Show-ahead FIFO: pop decided at the edge, head refreshed after test pushes.
    initial begin
        logic do_pop;
        bus.fifo_rdempty = 1'b1;
        bus.fifo_rddata  = '0;
        forever begin
            @(posedge clk);
            do_pop = !reset && bus.fifo_rdreq;
            #1;
            if (do_pop && fifo_q.size() > 0) void'(fifo_q.pop_front());
            #2;
            bus.fifo_rdempty = (fifo_q.size() == 0);
            bus.fifo_rddata  = (fifo_q.size() > 0) ? fifo_q[0] : 32'h0;
        end
    end

    // Sink ready pattern: 0 always, 1 toggle, 2 random, 3 stalled.
    initial begin
        bus.tx_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       bus.tx_ready = 1'b1;
                1:       bus.tx_ready = ~bus.tx_ready;
                2:       bus.tx_ready = ($urandom_range(0, 1) == 1);
                default: bus.tx_ready = 1'b0;
            endcase
        end
    end

    // Collect beats that will be accepted on the next edge; watch stalled beats stay put.
    initial begin
        beat_t cur;
        beat_t prev_beat;
        logic  prev_hold;
        prev_hold = 1'b0;
        prev_beat = '0;
        forever begin
            @(negedge clk);
            cur = {bus.tx_data, bus.tx_sop, bus.tx_eop, bus.tx_empty};
            if (reset) begin
                prev_hold = 1'b0;
            end else begin
                if (prev_hold && !(bus.tx_valid && cur === prev_beat)) hold_viol++;
                if (bus.tx_valid && bus.tx_ready) got_q.push_back(cur);
                if (frame_err) fe_pulses++;
                prev_hold = bus.tx_valid && !bus.tx_ready;
                prev_beat = cur;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: walk the word list by record rules and list the packets it should yield.
    task automatic model(input logic [31:0] w[$]);
        int i;
        int len;
        int nw;
        i = 0;
        while (i < w.size()) begin
            if (w[i] != START_WORD) begin
                i++;
                continue;
            end
            i++;
            if (i >= w.size()) break;
            len = int'(w[i][15:0]);
            i++;
            if (len > MAX_BYTES_DEFAULT) begin
                exp_err++;
                exp_fe++;
                while (i < w.size() && w[i] != STOP_WORD) i++;
                i++;
            end else begin
                nw = (len + 3) / 4;
                for (int k = 0; k < nw; k++) begin
                    beat_t b;
                    b.data  = w[i + k];
                    b.sop   = (k == 0);
                    b.eop   = (k == nw - 1);
                    b.empty = (k == nw - 1) ? 2'((4 - (len % 4)) % 4) : 2'd0;
                    exp_q.push_back(b);
                end
                if (nw > 0) exp_pkt++;
                i += nw;
                if (i < w.size() && w[i] != STOP_WORD) begin
                    exp_err++;
                    exp_fe++;
                end
                i++;
            end
        end
    endtask

    task automatic drain_and_compare(input string tag);
        logic timed_out;
        int   n;
        timed_out = 1'b1;
        for (int c = 0; c < 5000; c++) begin
            @(negedge clk);
            if (fifo_q.size() == 0 && !busy) begin
                timed_out = 1'b0;
                break;
            end
        end
        repeat (3) @(negedge clk);
        check({tag, "_drain_timeout"}, 64'(timed_out), 64'd0);
        check({tag, "_beat_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_beat%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
        end
        check({tag, "_pkt_count"}, 64'(pkt_count), 64'(exp_pkt));
        check({tag, "_err_count"}, 64'(err_count), 64'(exp_err));
        check({tag, "_frame_err_pulses"}, 64'(fe_pulses), 64'(exp_fe));
        check({tag, "_hold_stable"}, 64'(hold_viol), 64'd0);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic push_words(input logic [31:0] w[$]);
        @(posedge clk);
        #2;
        foreach (w[i]) fifo_q.push_back(w[i]);
    endtask

    task automatic send(input string tag, input logic [31:0] w[$], input int mode);
        ready_mode = mode;
        model(w);
        push_words(w);
        drain_and_compare(tag);
    endtask

    initial begin
        logic [31:0] w[$];
        logic [31:0] residue[$];
        logic        waited_ok;
        int          len;

        reset     = 1'b1;
        tx_enable = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_valid", 64'(bus.tx_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_pkt_count", 64'(pkt_count), 64'd0);
        check("rst_err_count", 64'(err_count), 64'd0);
        check("rst_frame_err", 64'(frame_err), 64'd0);
        check("rst_rdreq", 64'(bus.fifo_rdreq), 64'd0);
        @(posedge clk);
        #2;
        reset = 1'b0;

        w = '{START_WORD, 32'd7, 32'hA1A2A3A4, 32'hB1B2B3B4, STOP_WORD};
        send("basic", w, 0);
        send("toggle", w, 1);

        w = '{32'h12345678, START_WORD, 32'd4, 32'hC0C1C2C3, STOP_WORD};
        send("garbage", w, 0);

        w = '{START_WORD, 32'd2000, 32'h11111111, 32'h22222222, 32'h33333333, STOP_WORD,
              START_WORD, 32'd5, 32'hD0D1D2D3, 32'hE0E1E2E3, STOP_WORD};
        send("oversize", w, 2);

        w = '{START_WORD, 32'd4, 32'hCAFEBABE, 32'h0};
        send("bad_trailer", w, 0);

        w = '{START_WORD, 32'd0, STOP_WORD, START_WORD, 32'd1, 32'h99887766, STOP_WORD};
        send("zero_len", w, 1);

        // Disabled: nothing may be popped while hunting.
        tx_enable = 1'b0;
        w = '{START_WORD, 32'd6, 32'h01020304, 32'h05060708, STOP_WORD};
        push_words(w);
        repeat (20) @(negedge clk);
        check("disabled_fifo_untouched", 64'(fifo_q.size()), 64'd5);
        check("disabled_busy", 64'(busy), 64'd0);
        tx_enable = 1'b1;
        model(w);
        drain_and_compare("enabled_again");

        // Randomized records, garbage, bad trailers and oversize drops under random ready.
        w.delete();
        for (int r = 0; r < 8; r++) begin
            if ($urandom_range(0, 3) == 0) w.push_back(32'h0BAD0000 + 32'(r));
            len = ($urandom_range(0, 7) == 0) ? 1600 : int'($urandom_range(0, 40));
            w.push_back(START_WORD);
            w.push_back(32'(len));
            if (len > MAX_BYTES_DEFAULT) begin
                for (int k = 0; k < 3; k++) w.push_back(32'h5A000000 + 32'(k));
            end else begin
                for (int k = 0; k < (len + 3) / 4; k++) w.push_back($urandom);
            end
            w.push_back(($urandom_range(0, 5) == 0) ? 32'h0 : STOP_WORD);
        end
        send("random", w, 2);

        // Reset in the middle of an 8-word packet.
        ready_mode = 0;
        w = '{START_WORD, 32'd32};
        for (int k = 0; k < 8; k++) w.push_back(32'h10000000 + 32'(k));
        w.push_back(STOP_WORD);
        push_words(w);
        waited_ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (got_q.size() >= 3) begin
                waited_ok = 1'b1;
                break;
            end
        end
        check("midrst_reach_3_beats", 64'(waited_ok), 64'd1);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_tx_valid", 64'(bus.tx_valid), 64'd0);
        check("midrst_pkt_count", 64'(pkt_count), 64'd0);
        check("midrst_err_count", 64'(err_count), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        got_q.delete();
        exp_q.delete();
        exp_pkt = 0;
        exp_err = 0;
        residue = fifo_q;
        w = '{START_WORD, 32'd6, 32'hD1D2D3D4, 32'hE1E2E3E4, STOP_WORD};
        foreach (w[i]) residue.push_back(w[i]);
        model(residue);
        push_words(w);
        drain_and_compare("after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
